// File: rtl/sqg_pkg.sv
// rtl/sqg_pkg.sv - shared constants and FSM state type for the sqg sequencer
package sqg_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 64;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_DRAIN,
      S_NEXT
   } state_t;

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin arbiter, search starts at ptr and wraps
module rr_arb #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          any
);

   int            pos;
   logic [PW-1:0] idx;

   always_comb begin
      gnt = '0;
      pos = 0;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         pos = int'(ptr) + i;
         if (pos >= N) pos = pos - N;
         idx = PW'(pos);
         if (req[idx] && (gnt == '0)) gnt[idx] = 1'b1;
      end
      any = |req;
   end

endmodule

// File: rtl/sqg_sched.sv
// rtl/sqg_sched.sv - read-sweep sequencer and round-robin write arbiter for the sqg box array
module sqg_sched
   import sqg_pkg::*;
#(
   parameter int N_BOX  = 4,
   parameter int ADDR_W = sqg_pkg::ADDR_W,
   parameter int DEPTH  = sqg_pkg::DEPTH,
   parameter int DATA_W = sqg_pkg::DATA_W,
   parameter int DRAIN  = 3
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    start,
   input  logic                    bc_req,
   output logic                    busy,
   output logic                    done,
   output logic                    BC_mode,
   output logic [N_BOX-1:0]        box_en,
   output logic [ADDR_W-1:0]       rd_addr,
   input  logic [N_BOX-1:0]        wen_req,
   input  logic [N_BOX*ADDR_W-1:0] wr_addr_req,
   input  logic [N_BOX*DATA_W-1:0] wr_data_req,
   output logic [N_BOX-1:0]        gnt,
   output logic                    mem_wen,
   output logic [ADDR_W-1:0]       mem_waddr,
   output logic [DATA_W-1:0]       mem_wdata
);

   localparam int PW = (N_BOX > 1) ? $clog2(N_BOX) : 1;
   localparam int CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [PW-1:0]     LAST_BOX  = PW'(N_BOX - 1);
   localparam logic [CW-1:0]     LAST_CNT  = CW'(DRAIN - 1);
   localparam logic [N_BOX-1:0]  BOX0      = N_BOX'(1);

   state_t        state;
   logic [PW-1:0] box_sel;
   logic [CW-1:0] drain_cnt;
   logic [PW-1:0] ptr;
   logic [PW-1:0] gnt_idx;
   logic          any;
   logic          adv;

   rr_arb #(.N(N_BOX), .PW(PW)) u_arb (
      .req (wen_req),
      .ptr (ptr),
      .gnt (gnt),
      .any (any)
   );

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N_BOX; i++) begin
         if (gnt[i]) gnt_idx = PW'(i);
      end
   end

   // a stall is needed only when a second requester is left waiting this cycle
   assign adv = ((wen_req & ~gnt) == '0);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= S_IDLE;
         BC_mode   <= 1'b0;
         box_sel   <= '0;
         rd_addr   <= '0;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         box_en    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_SWEEP;
                  BC_mode <= bc_req;
                  box_sel <= '0;
                  rd_addr <= '0;
                  busy    <= 1'b1;
                  box_en  <= bc_req ? '1 : BOX0;
               end
            end
            S_SWEEP: begin
               if (adv) begin
                  if (rd_addr == LAST_ADDR) begin
                     state     <= S_DRAIN;
                     drain_cnt <= '0;
                  end else begin
                     rd_addr <= rd_addr + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_cnt != LAST_CNT) begin
                  drain_cnt <= drain_cnt + 1'b1;
               end else if (wen_req == '0) begin
                  state  <= S_NEXT;
                  box_en <= '0;
               end
            end
            S_NEXT: begin
               rd_addr <= '0;
               if (BC_mode || (box_sel == LAST_BOX)) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state   <= S_SWEEP;
                  box_sel <= box_sel + 1'b1;
                  box_en  <= BOX0 << (box_sel + 1'b1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // write port and priority pointer run in every state so late write-backs land
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ptr       <= '0;
         mem_wen   <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
      end else begin
         mem_wen <= any;
         if (any) begin
            ptr       <= (gnt_idx == LAST_BOX) ? '0 : gnt_idx + 1'b1;
            mem_waddr <= wr_addr_req[int'(gnt_idx)*ADDR_W +: ADDR_W];
            mem_wdata <= wr_data_req[int'(gnt_idx)*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: tb/tb_sqg_sched.sv
// tb/tb_sqg_sched.sv - self-checking bench for sqg_sched with a pass-position model
module tb_sqg_sched;

   localparam int NB  = 4;
   localparam int DEP = 64;
   localparam int DRN = 3;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0;
   logic        bc_req = 1'b0;
   logic        busy, done, BC_mode;
   logic [3:0]  box_en;
   logic [5:0]  rd_addr;
   logic [3:0]  wen_req = 4'b0;
   logic [23:0] wr_addr_req = '0;
   logic [31:0] wr_data_req = '0;
   logic [3:0]  gnt;
   logic        mem_wen;
   logic [5:0]  mem_waddr;
   logic [7:0]  mem_wdata;

   sqg_sched dut (
      .CLK         (CLK),
      .RST         (RST),
      .start       (start),
      .bc_req      (bc_req),
      .busy        (busy),
      .done        (done),
      .BC_mode     (BC_mode),
      .box_en      (box_en),
      .rd_addr     (rd_addr),
      .wen_req     (wen_req),
      .wr_addr_req (wr_addr_req),
      .wr_data_req (wr_data_req),
      .gnt         (gnt),
      .mem_wen     (mem_wen),
      .mem_waddr   (mem_waddr),
      .mem_wdata   (mem_wdata)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   logic cmp_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // model: position inside the current pass (0..DEP-1 sweep, then drain, then the hand-off cycle)
   logic m_busy = 0, m_done = 0, m_bc = 0, m_wen = 0;
   int   m_box = 0, m_pos = 0, m_ptr = 0;
   logic [5:0] m_waddr = '0;
   logic [7:0] m_wdata = '0;

   function automatic logic [3:0] m_arb(input logic [3:0] r, input int p);
      logic [3:0] g;
      int k;
      g = '0;
      for (int d = 0; d < NB; d++) begin
         k = (p + d) % NB;
         if ((g == '0) && (((r >> k) & 4'd1) != 4'd0)) g = 4'b0001 << k;
      end
      return g;
   endfunction

   function automatic int onehot_idx(input logic [3:0] g);
      int r;
      r = -1;
      for (int k = 0; k < NB; k++) if (((g >> k) & 4'd1) != 4'd0) r = k;
      return r;
   endfunction

   always @(posedge CLK or negedge RST) begin
      logic [3:0] g;
      int k;
      if (!RST) begin
         m_busy = 0; m_done = 0; m_bc = 0; m_wen = 0;
         m_box = 0; m_pos = 0; m_ptr = 0; m_waddr = '0; m_wdata = '0;
      end else begin
         g = m_arb(wen_req, m_ptr);
         k = onehot_idx(g);
         m_done = 0;
         if (!m_busy) begin
            if (start) begin
               m_busy = 1; m_bc = bc_req; m_box = 0; m_pos = 0;
            end
         end else if (m_pos < DEP) begin
            if ((wen_req & ~g) == 4'b0) m_pos++;
         end else if (m_pos < DEP + DRN - 1) begin
            m_pos++;
         end else if (m_pos == DEP + DRN - 1) begin
            if (wen_req == 4'b0) m_pos++;
         end else begin
            m_pos = 0;
            if (m_bc || (m_box == NB - 1)) begin
               m_busy = 0; m_done = 1;
            end else begin
               m_box++;
            end
         end
         m_wen = (k >= 0);
         if (k >= 0) begin
            m_waddr = 6'(wr_addr_req >> (k * 6));
            m_wdata = 8'(wr_data_req >> (k * 8));
            m_ptr   = (k + 1) % NB;
         end
      end
   end

   logic [3:0]  gl = '0;
   int          gq[$];
   logic [13:0] mq[$];

   always @(negedge CLK) begin
      int e_addr;
      int e_en;
      gl = gnt;
      if (cmp_en) begin
         e_addr = m_busy ? ((m_pos < DEP) ? m_pos : DEP - 1) : 0;
         e_en   = (m_busy && (m_pos < DEP + DRN)) ? (m_bc ? 15 : (1 << m_box)) : 0;
         chk("cmp_gnt",     int'(gnt),       int'(m_arb(wen_req, m_ptr)));
         chk("cmp_busy",    int'(busy),      int'(m_busy));
         chk("cmp_done",    int'(done),      int'(m_done));
         chk("cmp_bc_mode", int'(BC_mode),   int'(m_bc));
         chk("cmp_box_en",  int'(box_en),    e_en);
         chk("cmp_rd_addr", int'(rd_addr),   e_addr);
         chk("cmp_mem_wen", int'(mem_wen),   int'(m_wen));
         if (m_wen) begin
            chk("cmp_mem_waddr", int'(mem_waddr), int'(m_waddr));
            chk("cmp_mem_wdata", int'(mem_wdata), int'(m_wdata));
         end
         if (gnt != 4'b0) gq.push_back(onehot_idx(gnt));
         if (mem_wen) mq.push_back({mem_waddr, mem_wdata});
      end
   end

   // box behaviour: hold each request until granted; scenario-driven request injection
   int scen = 0;
   int last_scen = -1;
   logic fired = 0;
   int cnt63 = -1;

   always @(posedge CLK) begin
      #1;
      wen_req = wen_req & ~gl;
      if (scen != last_scen) begin
         fired = 0; cnt63 = -1; last_scen = scen;
      end
      if (scen == 3 && !fired && busy && rd_addr == 6'd10) begin
         wen_req = 4'b1111;
         fired = 1;
      end
      if ((scen == 4 || scen == 5) && !fired && busy) begin
         if (cnt63 >= 0) cnt63++;
         else if (rd_addr == 6'd63) cnt63 = 0;
         if (cnt63 == ((scen == 4) ? 2 : 3)) begin
            wen_req = wen_req | 4'b0100;
            fired = 1;
         end
      end
   end

   logic [5:0] addr_log [0:1023];
   logic [3:0] en_log   [0:1023];
   int plen;

   task automatic pulse_start(input logic bc);
      @(posedge CLK); #1;
      start = 1'b1; bc_req = bc;
      @(posedge CLK); #1;
      start = 1'b0; bc_req = 1'b0;
   endtask

   task automatic wait_pass();
      int first;
      first = -1;
      plen = -1;
      for (int c = 0; c < 1000; c++) begin
         @(negedge CLK);
         if (busy && first < 0) first = c;
         if (first >= 0 && (c - first) < 1024) begin
            addr_log[c - first] = rd_addr;
            en_log[c - first]   = box_en;
         end
         if (done && first >= 0) begin
            plen = c - first;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 RST = 1'b0;
      #1;
      chk("rst_busy",    int'(busy),    0);
      chk("rst_done",    int'(done),    0);
      chk("rst_bc_mode", int'(BC_mode), 0);
      chk("rst_box_en",  int'(box_en),  0);
      chk("rst_rd_addr", int'(rd_addr), 0);
      chk("rst_mem_wen", int'(mem_wen), 0);
      cmp_en = 1'b1;
      @(negedge CLK); @(negedge CLK);
      RST = 1'b1;

      // broadcast pass with no writers
      scen = 1;
      pulse_start(1'b1);
      wait_pass();
      chk("bc_len",       plen, 68);
      chk("bc_addr0",     int'(addr_log[0]),  0);
      chk("bc_addr10",    int'(addr_log[10]), 10);
      chk("bc_addr63",    int'(addr_log[63]), 63);
      chk("bc_addr_drn",  int'(addr_log[66]), 63);
      chk("bc_en0",       int'(en_log[0]),    15);
      chk("bc_en_drn",    int'(en_log[66]),   15);
      chk("bc_en_next",   int'(en_log[67]),   0);
      chk("bc_mode_held", int'(BC_mode),      1);

      // sequential passes
      scen = 2;
      pulse_start(1'b0);
      wait_pass();
      chk("seq_len",      plen, 272);
      chk("seq_en_b0",    int'(en_log[0]),   1);
      chk("seq_en_next0", int'(en_log[67]),  0);
      chk("seq_en_b1",    int'(en_log[68]),  2);
      chk("seq_addr_b1",  int'(addr_log[68]), 0);
      chk("seq_en_b2",    int'(en_log[136]), 4);
      chk("seq_en_b3",    int'(en_log[204]), 8);
      chk("seq_addr_b3",  int'(addr_log[267]), 63);
      chk("seq_bc_mode",  int'(BC_mode), 0);

      // broadcast stall: all four boxes request at rd_addr 10
      wr_addr_req = {6'd43, 6'd42, 6'd41, 6'd40};
      wr_data_req = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      gq.delete(); mq.delete();
      scen = 3;
      pulse_start(1'b1);
      wait_pass();
      chk("stall_len",   plen, 71);
      chk("stall_a10_a", int'(addr_log[10]), 10);
      chk("stall_a10_d", int'(addr_log[13]), 10);
      chk("stall_a11",   int'(addr_log[14]), 11);
      chk("stall_ngnt",  gq.size(), 4);
      chk("stall_nwr",   mq.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < gq.size()) chk("stall_gnt_order", gq[i], i);
         if (i < mq.size()) chk("stall_wr_slice", int'(mq[i]), int'({6'(40 + i), 8'(8'hA0 + i)}));
      end

      // late write-back from box 2 one cycle into drain
      wr_addr_req = {6'd0, 6'd63, 6'd0, 6'd0};
      wr_data_req = {8'd0, 8'd30, 8'd0, 8'd0};
      gq.delete(); mq.delete();
      scen = 4;
      pulse_start(1'b1);
      wait_pass();
      chk("drn1_len", plen, 68);
      chk("drn1_nwr", mq.size(), 1);
      if (mq.size() > 0) chk("drn1_wr", int'(mq[0]), int'({6'd63, 8'd30}));

      // request still up on the last drain cycle: hand-off waits one cycle
      mq.delete();
      scen = 5;
      pulse_start(1'b1);
      wait_pass();
      chk("drn2_len", plen, 69);
      chk("drn2_nwr", mq.size(), 1);
      if (mq.size() > 0) chk("drn2_wr", int'(mq[0]), int'({6'd63, 8'd30}));

      // asynchronous reset mid-sweep
      scen = 6;
      pulse_start(1'b1);
      begin
         int seen;
         seen = 0;
         for (int c = 0; c < 200 && seen == 0; c++) begin
            @(negedge CLK);
            if (rd_addr == 6'd20) seen = 1;
         end
         chk("rst_mid_reached", seen, 1);
      end
      #2 RST = 1'b0;
      #1;
      chk("rst_mid_busy",   int'(busy),      0);
      chk("rst_mid_box_en", int'(box_en),    0);
      chk("rst_mid_rd",     int'(rd_addr),   0);
      chk("rst_mid_bc",     int'(BC_mode),   0);
      chk("rst_mid_waddr",  int'(mem_waddr), 0);
      chk("rst_mid_wdata",  int'(mem_wdata), 0);
      @(negedge CLK); @(negedge CLK);
      RST = 1'b1;
      scen = 7;
      pulse_start(1'b1);
      wait_pass();
      chk("post_rst_len",   plen, 68);
      chk("post_rst_addr0", int'(addr_log[0]), 0);

      // start pulsed while busy is ignored
      scen = 8;
      fork
         wait_pass();
         begin
            pulse_start(1'b1);
            repeat (5) @(posedge CLK);
            #1 start = 1'b1; bc_req = 1'b0;
            @(posedge CLK);
            #1 start = 1'b0;
         end
      join
      chk("busy_start_len", plen, 68);
      chk("busy_start_bc",  int'(BC_mode), 1);
      repeat (3) @(negedge CLK);
      chk("busy_start_idle", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
